// File: rtl/split_two_outputs.sv
// Fan-out stage: pops one sample from the input FIFO and pushes identical copies
// into two output FIFOs. Each output drains independently of the other.
module split_two_outputs #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                         clock,
   input  logic                         reset,
   output logic                         in_rd_en,
   input  logic                         in_empty,
   input  logic signed [DATA_WIDTH-1:0] in_dout,
   output logic                         outA_wr_en,
   input  logic                         outA_full,
   output logic signed [DATA_WIDTH-1:0] outA_din,
   output logic                         outB_wr_en,
   input  logic                         outB_full,
   output logic signed [DATA_WIDTH-1:0] outB_din,
   output logic        [CNT_WIDTH-1:0]  sample_count,
   output logic                         busy
);

   typedef enum logic [1:0] {
      S_LOAD = 2'b00,
      S_SEND = 2'b01
   } state_t;

   state_t                         state, state_n;
   logic signed [DATA_WIDTH-1:0]   data, data_n;
   logic                           pend_a, pend_a_n;
   logic                           pend_b, pend_b_n;
   logic        [CNT_WIDTH-1:0]    count, count_n;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state  <= S_LOAD;
         data   <= '0;
         pend_a <= 1'b0;
         pend_b <= 1'b0;
         count  <= '0;
      end else begin
         state  <= state_n;
         data   <= data_n;
         pend_a <= pend_a_n;
         pend_b <= pend_b_n;
         count  <= count_n;
      end
   end

   // A sample retires only once both pending flags are clear, so a stalled
   // branch holds the data without re-pushing to the branch already served.
   always_comb begin
      state_n  = state;
      data_n   = data;
      pend_a_n = pend_a;
      pend_b_n = pend_b;
      count_n  = count;
      case (state)
         S_LOAD: begin
            if (!in_empty) begin
               data_n   = in_dout;
               pend_a_n = 1'b1;
               pend_b_n = 1'b1;
               state_n  = S_SEND;
            end
         end
         S_SEND: begin
            if (outA_wr_en) pend_a_n = 1'b0;
            if (outB_wr_en) pend_b_n = 1'b0;
            if (!pend_a_n && !pend_b_n) begin
               count_n = count + CNT_WIDTH'(1);
               state_n = S_LOAD;
            end
         end
         default: begin
            state_n  = S_LOAD;
            pend_a_n = 1'b0;
            pend_b_n = 1'b0;
         end
      endcase
   end

   always_comb begin
      in_rd_en   = 1'b0;
      outA_wr_en = 1'b0;
      outB_wr_en = 1'b0;
      busy       = 1'b0;
      case (state)
         S_LOAD: in_rd_en = !in_empty;
         S_SEND: begin
            busy       = 1'b1;
            outA_wr_en = pend_a && !outA_full;
            outB_wr_en = pend_b && !outB_full;
         end
         default: ;
      endcase
      outA_din = outA_wr_en ? data : '0;
      outB_din = outB_wr_en ? data : '0;
   end

   assign sample_count = count;

endmodule

// File: tb/tb_split_two_outputs.sv
// Randomized scoreboard bench for split_two_outputs: every enqueued input sample
// is expected exactly once, in order, on each output.
module tb_split_two_outputs;
   localparam int DW = 32;
   localparam int CW = 4;

   logic                 clock = 1'b0;
   logic                 reset;
   logic                 in_rd_en;
   logic                 in_empty;
   logic signed [DW-1:0] in_dout;
   logic                 outA_wr_en, outA_full;
   logic signed [DW-1:0] outA_din;
   logic                 outB_wr_en, outB_full;
   logic signed [DW-1:0] outB_din;
   logic        [CW-1:0] sample_count;
   logic                 busy;

   always #5 clock = ~clock;

   split_two_outputs #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
      .clock(clock), .reset(reset),
      .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
      .outA_wr_en(outA_wr_en), .outA_full(outA_full), .outA_din(outA_din),
      .outB_wr_en(outB_wr_en), .outB_full(outB_full), .outB_din(outB_din),
      .sample_count(sample_count), .busy(busy)
   );

   int n_chk = 0, n_pass = 0;
   int cyc = 0;
   logic [DW-1:0] in_q[$], exp_a[$], exp_b[$];
   bit  force_empty = 0;
   int  mode_a = 0, mode_b = 0;      // 0 never full, 1 always, 2/3 toggling, 4 random
   int  pop_count = 0, wr_a_count = 0, wr_b_count = 0, last_pop_cyc = -10;
   bit  chk_lat_a = 0, chk_lat_b = 0;
   int  expected_done = 0;

   task automatic chk(input string name, input bit ok, input logic [63:0] act, input logic [63:0] expv);
      n_chk++;
      if (ok) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
   endtask

   function automatic bit full_of(input int m);
      case (m)
         0: return 1'b0;
         1: return 1'b1;
         2: return cyc[0];
         3: return !cyc[0];
         default: return 1'($urandom_range(0, 1));
      endcase
   endfunction

   // Input FIFO and output-full model: drives inputs on the falling edge.
   initial begin
      in_empty = 1'b1; in_dout = '0; outA_full = 1'b0; outB_full = 1'b0;
      forever begin
         @(negedge clock);
         cyc++;
         in_empty  = force_empty || (in_q.size() == 0);
         in_dout   = (in_q.size() != 0) ? in_q[0] : 32'hDEADBEEF;
         outA_full = full_of(mode_a);
         outB_full = full_of(mode_b);
         #1;
         if (in_rd_en) begin
            chk("rd_while_nonempty", !in_empty, in_empty, 0);
            if (!in_empty) begin
               void'(in_q.pop_front());
               pop_count++;
               last_pop_cyc = cyc;
            end
         end
      end
   end

   // Monitor: pops the scoreboard whenever an output push is presented.
   initial begin
      logic [DW-1:0] e;
      forever begin
         @(negedge clock);
         #2;
         if (outA_wr_en) begin
            wr_a_count++;
            chk("a_push_when_full", !outA_full, outA_full, 0);
            if (exp_a.size() == 0) chk("a_unexpected_push", 0, outA_din, 0);
            else begin
               e = exp_a.pop_front();
               chk("a_data", outA_din == e, outA_din, e);
            end
            if (chk_lat_a) chk("a_latency", cyc == last_pop_cyc + 1, cyc, last_pop_cyc + 1);
         end else if (outA_din != '0) chk("a_din_idle", 0, outA_din, 0);
         if (outB_wr_en) begin
            wr_b_count++;
            chk("b_push_when_full", !outB_full, outB_full, 0);
            if (exp_b.size() == 0) chk("b_unexpected_push", 0, outB_din, 0);
            else begin
               e = exp_b.pop_front();
               chk("b_data", outB_din == e, outB_din, e);
            end
            if (chk_lat_b) chk("b_latency", cyc == last_pop_cyc + 1, cyc, last_pop_cyc + 1);
         end else if (outB_din != '0) chk("b_din_idle", 0, outB_din, 0);
      end
   end

   task automatic step();
      @(negedge clock);
      #3;
   endtask

   task automatic enqueue(input logic [DW-1:0] v);
      in_q.push_back(v);
      exp_a.push_back(v);
      exp_b.push_back(v);
      expected_done++;
   endtask

   task automatic drain(input string name);
      int t = 0;
      step();
      while ((in_q.size() != 0 || exp_a.size() != 0 || exp_b.size() != 0 || busy) && t < 2000) begin
         step();
         t++;
      end
      chk({name, "_drain_timeout"}, t < 2000, t, 2000);
      chk({name, "_sample_count"}, sample_count == CW'(expected_done), sample_count, CW'(expected_done));
   endtask

   task automatic wait_pop(input int p0, input string name);
      int t = 0;
      while (pop_count == p0 && t < 50) begin
         step();
         t++;
      end
      chk({name, "_pop_timeout"}, t < 50, t, 50);
   endtask

   initial begin
      int p0, a0, b0, bad;
      reset = 1'b1;
      step();
      chk("rst_rd_en", in_rd_en == 0, in_rd_en, 0);
      chk("rst_strobes", {outA_wr_en, outB_wr_en} == 2'b00, {outA_wr_en, outB_wr_en}, 0);
      chk("rst_dins", outA_din == 0 && outB_din == 0, {outA_din, outB_din}, 0);
      chk("rst_busy", busy == 0, busy, 0);
      chk("rst_count", sample_count == 0, sample_count, 0);
      reset = 1'b0;

      // Basic fan-out, including extreme signed values.
      chk_lat_a = 1; chk_lat_b = 1;
      p0 = pop_count; a0 = wr_a_count; b0 = wr_b_count;
      enqueue(32'd5); enqueue(-32'sd7); enqueue(32'h7FFFFFFF); enqueue(32'h80000000);
      drain("basic");
      chk("basic_pops", pop_count - p0 == 4, pop_count - p0, 4);
      chk("basic_a_pushes", wr_a_count - a0 == 4, wr_a_count - a0, 4);
      chk("basic_b_pushes", wr_b_count - b0 == 4, wr_b_count - b0, 4);
      chk_lat_a = 0;

      // Stalled A: B served immediately, A waits, no new pop meanwhile.
      mode_a = 1;
      p0 = pop_count; a0 = wr_a_count; b0 = wr_b_count;
      enqueue(32'd100); enqueue(32'd101);
      wait_pop(p0, "stall");
      chk_lat_b = 0;
      bad = 0;
      for (int i = 0; i < 9; i++) begin
         step();
         if (!busy) bad++;
      end
      chk("stall_busy", bad == 0, bad, 0);
      chk("stall_no_second_pop", pop_count == p0 + 1, pop_count - p0, 1);
      chk("stall_no_a_push", wr_a_count == a0, wr_a_count - a0, 0);
      chk("stall_b_once", wr_b_count == b0 + 1, wr_b_count - b0, 1);
      mode_a = 0;
      step();
      chk("stall_a_on_release", wr_a_count == a0 + 1, wr_a_count - a0, 1);
      chk("stall_pop_after_a", pop_count == p0 + 1, pop_count - p0, 1);
      drain("stall");
      chk("stall_a_total", wr_a_count - a0 == 2, wr_a_count - a0, 2);

      // Alternating out-of-phase stalls.
      mode_a = 2; mode_b = 3;
      a0 = wr_a_count; b0 = wr_b_count;
      for (int i = 1; i <= 8; i++) enqueue(DW'(i));
      drain("alt");
      chk("alt_a_pushes", wr_a_count - a0 == 8, wr_a_count - a0, 8);
      chk("alt_b_pushes", wr_b_count - b0 == 8, wr_b_count - b0, 8);
      mode_a = 0; mode_b = 0;

      // Empty input: no strobes while the FIFO reports empty.
      force_empty = 1;
      p0 = pop_count; a0 = wr_a_count; b0 = wr_b_count;
      enqueue(32'hFFFFFFFF);
      for (int i = 0; i < 20; i++) step();
      chk("empty_no_pop", pop_count == p0, pop_count - p0, 0);
      chk("empty_no_push", wr_a_count == a0 && wr_b_count == b0, wr_a_count - a0 + wr_b_count - b0, 0);
      force_empty = 0;
      drain("empty");
      chk("empty_one_pop", pop_count - p0 == 1, pop_count - p0, 1);

      // Reset while A still pending: the sample is dropped.
      mode_a = 1;
      p0 = pop_count;
      enqueue(32'd42);
      wait_pop(p0, "rstmid");
      step();
      reset = 1'b1;
      #1;
      chk("rstmid_strobes", {in_rd_en, outA_wr_en, outB_wr_en} == 3'b000, {in_rd_en, outA_wr_en, outB_wr_en}, 0);
      chk("rstmid_dins", outA_din == 0 && outB_din == 0, {outA_din, outB_din}, 0);
      chk("rstmid_busy", busy == 0, busy, 0);
      chk("rstmid_count", sample_count == 0, sample_count, 0);
      step();
      reset = 1'b0;
      chk("rstmid_a_pending", exp_a.size() == 1, exp_a.size(), 1);
      if (exp_a.size() != 0) void'(exp_a.pop_front());
      expected_done = 0;
      mode_a = 0;
      a0 = wr_a_count;
      for (int i = 0; i < 5; i++) step();
      chk("rstmid_no_a_push", wr_a_count == a0, wr_a_count - a0, 0);
      chk("rstmid_idle", busy == 0, busy, 0);

      // Counter wrap with random data and random backpressure.
      mode_a = 4; mode_b = 4;
      for (int i = 0; i < 17; i++) enqueue($urandom);
      drain("wrap");
      chk("wrap_count_is_1", sample_count == 4'd1, sample_count, 1);
      for (int i = 0; i < 30; i++) enqueue($urandom);
      drain("random");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/split_two_outputs.md
Name: split_two_outputs

Overview:
Fan-out stage for the FIFO-streamed DSP chain. It pops one signed 32-bit sample from a single input FIFO and pushes an identical copy into each of two output FIFOs. Typical use is after FM demodulation, where one sample stream must feed both the audio low-pass path and the pilot band-pass path.
The two outputs drain independently, so one stalled branch never causes a duplicated or dropped sample on the other.

Parameters:
DATA_WIDTH, 32, sample width in bits; samples are signed two's complement.
CNT_WIDTH, 32, width of the completed-sample counter.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
in_rd_en  output  1  pop strobe to the input FIFO (show-ahead: in_dout is valid while !in_empty).
in_empty  input  1  input FIFO empty.
in_dout  input  DATA_WIDTH  input FIFO head sample, signed.
outA_wr_en  output  1  push strobe to output FIFO A.
outA_full  input  1  output FIFO A full.
outA_din  output  DATA_WIDTH  data to output FIFO A, signed.
outB_wr_en  output  1  push strobe to output FIFO B.
outB_full  input  1  output FIFO B full.
outB_din  output  DATA_WIDTH  data to output FIFO B, signed.
sample_count  output  CNT_WIDTH  number of samples delivered to both outputs.
busy  output  1  high while a captured sample is still pending on either output.

Behaviour:
- Reset is asynchronous, active-high; clock is `clock`, rising edge.
- Registered state: state, data register, pendA, pendB, sample_count.
- Reset values:
  - state = S_LOAD; data = 0; pendA = pendB = 0; sample_count = 0.
  - All strobes low; outA_din = outB_din = 0; busy = 0.
- All strobes and the din outputs are combinational from the registered state plus the FIFO flags.
- din outputs:
  - outA_din equals data when outA_wr_en = 1, else 0.
  - outB_din follows the same rule.
- No arithmetic is applied: outputs are bit-exact copies of the input sample, with no width change.
- S_LOAD:
  - busy = 0.
  - If !in_empty: in_rd_en = 1; next data = in_dout; next pendA = pendB = 1; next state = S_SEND.
  - Otherwise hold, with in_rd_en = 0.
- S_SEND:
  - busy = 1; in_rd_en = 0.
  - outA_wr_en = pendA && !outA_full; outB_wr_en = pendB && !outB_full.
  - Each pending flag clears in the cycle its write fires.
  - A flag already cleared never re-asserts its strobe, so exactly one push per output per sample.
  - When both flags are (or become) clear this cycle: sample_count increments by 1 and next state = S_LOAD.
  - Otherwise remain in S_SEND.
- Latency and throughput:
  - The first pushes happen in the cycle after the pop.
  - Best-case throughput is one sample per 2 cycles; there is no pop in S_SEND.
- Both outputs non-full: both strobes fire in the same cycle.
- One output full: the other output writes and clears its flag; the stalled output waits indefinitely with its flag held and data held.
- Both outputs full: no strobes, no state change.
- in_empty in S_LOAD: idle, no reads. in_empty is ignored in S_SEND.
- sample_count wraps modulo 2^CNT_WIDTH with no saturation or flag.
- Reset mid-operation (in S_SEND): the pending sample is discarded and no further strobes are issued. The upstream pop is not undone, so that sample is lost by design.
- Illegal state encoding: next state = S_LOAD, flags cleared.

Test Plan:
- Basic fan-out:
  - Stimulus: input FIFO holds 5, -7, 0x7FFFFFFF, 0x80000000; outputs never full.
  - Required response: A and B each receive the same 4 values in order, each push one cycle after its pop; sample_count = 4; exactly 4 in_rd_en pulses.
- Stalled A:
  - Stimulus: sample 100; outA_full held high for 10 cycles.
  - Required response: B written once at cycle +1. A written once at the first cycle outA_full is low. No second pop until then; busy high throughout the stall.
- Alternating stalls:
  - Stimulus: samples 1..8; outA_full and outB_full toggle out of phase every cycle.
  - Required response: both outputs receive exactly 1..8 in order, with no duplicates or drops; sample_count = 8.
- Empty input:
  - Stimulus: in_empty high for 20 cycles, then sample -1 arrives.
  - Required response: no strobes during the 20 cycles; then one pop and 0xFFFFFFFF on both outputs.
- Reset mid-send:
  - Stimulus: capture sample 42 with outA_full high, then assert reset for 1 cycle.
  - Required response: no write of 42 to A after reset; state = S_LOAD; sample_count = 0; all outputs 0.
- Counter wrap:
  - Stimulus: build with CNT_WIDTH = 4; stream 17 samples.
  - Required response: sample_count = 1.
